// File: rtl/cnt_serializer_7_3.sv
// Count-word to thermometer-frame serializer.
// Each accepted count word c (0..N) becomes one N-bit frame whose bit i is 1 when i < c.
// Frames leave LSB first, one bit per out_valid/out_ready handshake. Words queue in a small
// FIFO so consecutive frames are emitted without bubbles.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - count word offered
//   in_cnt     - ones-count to expand into one frame
//   in_ready   - FIFO can accept a word this cycle (registered state only)
//   out_valid  - out_bit/out_last are valid
//   out_ready  - downstream accepts the current bit
//   out_bit    - current serial frame bit
//   out_last   - marks bit index N-1 of a frame
//   frame_vec  - thermometer image of the frame being sent (holds after the frame ends)
//   fifo_level - entries held in the FIFO
module cnt_serializer_7_3 #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned N     = 7,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [N-1:0]     frame_vec,
  output logic [LVL_W-1:0] fifo_level
);

  localparam logic [CNT_W-1:0] IdxLast = CNT_W'(N - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       frame_q, frame_d;
  logic [CNT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;

  logic             push, pop, beat, last_beat;
  logic [CNT_W-1:0] head;

  // in_ready depends only on the registered level: a full FIFO refuses a word even when a
  // pop happens on the same edge.
  assign in_ready   = (level_q < LVL_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign beat       = (state_q == StShift) && out_ready;
  assign last_beat  = beat && (idx_q == IdxLast);
  // Pop when idle with data waiting, or on the final accepted beat so the next frame
  // starts on the following cycle without a gap.
  assign pop        = (level_q != '0) && ((state_q == StIdle) || last_beat);
  assign fifo_level = level_q;
  assign frame_vec  = frame_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (pop) begin
      state_d = StShift;
      idx_d   = '0;
      for (int unsigned i = 0; i < N; i++) begin
        frame_d[i] = (i < 32'(head));
      end
    end else if (last_beat) begin
      state_d = StIdle;
      idx_d   = '0;
    end else if (beat) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    if (state_q == StShift) begin
      out_valid = 1'b1;
      out_bit   = frame_q[idx_q];
      out_last  = (idx_q == IdxLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      frame_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= in_cnt;
    end
  end

endmodule

// File: tb/tb_cnt_serializer_7_3.sv
// Self-checking bench for cnt_serializer_7_3: scoreboard of expected frame bits filled on
// accepted pushes and drained on accepted output beats, plus directed checks.
module tb_cnt_serializer_7_3;

  localparam int N = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_cnt;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic [6:0] frame_vec;
  logic [2:0] fifo_level;

  cnt_serializer_7_3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_cnt    (in_cnt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .frame_vec (frame_vec),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  bit       bit_q[$];
  int       cnt_q[$];
  int       beat_i;
  bit [6:0] frame_got;
  int       frames_done;
  int       pushed;
  bit       prev_stall;
  logic     prev_bit, prev_last;
  bit       watch, seen_valid;
  int       bubbles, watch_beats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcnt(input bit [6:0] v);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(v[i]);
    return s;
  endfunction

  // Drive one cycle of inputs at a falling edge, observe handshakes just before the
  // rising edge, then return at the next falling edge.
  task automatic step(input logic v, input logic [2:0] c, input logic r, input logic rs);
    bit eb;
    in_valid  = v;
    in_cnt    = c;
    out_ready = r;
    rst       = rs;
    #4;
    if (rs) begin
      bit_q.delete();
      cnt_q.delete();
      beat_i     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_bit", 32'(out_bit), 32'(prev_bit));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (watch) begin
        if (out_valid) seen_valid = 1'b1;
        else if (seen_valid && bit_q.size() != 0) bubbles++;
      end
      if (in_valid && in_ready) begin
        pushed++;
        cnt_q.push_back(int'(c));
        for (int i = 0; i < N; i++) bit_q.push_back(i < int'(c));
      end
      if (out_valid && out_ready) begin
        if (watch) watch_beats++;
        if (bit_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          eb = bit_q.pop_front();
          check("bit", 32'(out_bit), 32'(eb));
          check("last", 32'(out_last), 32'(beat_i == N - 1));
          frame_got[beat_i] = out_bit;
          beat_i++;
          if (beat_i == N) begin
            check("ones", 32'(popcnt(frame_got)), 32'(cnt_q.pop_front()));
            beat_i = 0;
            frames_done++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_bit   = out_bit;
      prev_last  = out_last;
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit rnd);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (bit_q.size() == 0 && !out_valid && fifo_level == 0) done = 1'b1;
      else step(1'b0, 3'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int f0;
    bit hit;
    in_valid  = 1'b0;
    in_cnt    = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bit", 32'(out_bit), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_frame", 32'(frame_vec), 32'd0);

    // Single word with latency check
    step(1'b1, 3'd3, 1'b1, 1'b0);
    check("lat_valid0", 32'(out_valid), 32'd0);
    check("lat_level1", 32'(fifo_level), 32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    check("lat_valid1", 32'(out_valid), 32'd1);
    check("lat_bit0", 32'(out_bit), 32'd1);
    check("lat_level0", 32'(fifo_level), 32'd0);
    drain(1'b0);
    check("single_frame", 32'(frame_vec), 32'h07);
    check("single_idle", 32'(out_valid), 32'd0);

    // Back-to-back 0, 7, 5
    watch = 1'b1; seen_valid = 1'b0; bubbles = 0; watch_beats = 0;
    step(1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    drain(1'b0);
    watch = 1'b0;
    check("b2b_bubbles", 32'(bubbles), 32'd0);
    check("b2b_beats", 32'(watch_beats), 32'd21);
    check("b2b_frame", 32'(frame_vec), 32'h1f);

    // Backpressure fills the FIFO; the sixth word is refused
    f0 = frames_done;
    for (int k = 0; k < 6; k++) step(1'b1, 3'(k + 1), 1'b0, 1'b0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    check("full_level_hold", 32'(fifo_level), 32'd4);
    drain(1'b0);
    check("full_frames", 32'(frames_done - f0), 32'd5);

    // Stall hold during a cnt=4 frame
    step(1'b1, 3'd4, 1'b0, 1'b0);
    drain(1'b1);

    // Reset mid-frame with two queued words
    step(1'b1, 3'd7, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (beat_i == 2 && out_valid) hit = 1'b1;
      else step(1'b0, 3'd0, 1'b1, 1'b0);
    end
    check("mid_reached", 32'(hit), 32'd1);
    check("mid_level_pre", 32'(fifo_level), 32'd2);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_level", 32'(fifo_level), 32'd0);
    check("mid_frame", 32'(frame_vec), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    drain(1'b0);
    check("mid_after_frame", 32'(frame_vec), 32'h01);

    // Random traffic
    f0 = frames_done;
    pushed = 0;
    for (int k = 0; k < 30000 && pushed < 1200; k++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain(1'b1);
    check("rand_frames", 32'(frames_done - f0), 32'(pushed));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
